// File: rtl/crossbar_pkg.sv
// crossbar_pkg: shared sizes, FSM states and helpers for the crossbar scheduler
package crossbar_pkg;
    localparam int CPU_N  = 4;
    localparam int MM_N   = 4;
    localparam int IDX_W  = 2;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARB     = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    function automatic logic [CPU_N-1:0] onehot(input logic [IDX_W-1:0] idx);
        return CPU_N'(1) << idx;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: circular priority search for the first set request starting at ptr
module rr_arbiter
    import crossbar_pkg::*;
(
    input  logic [CPU_N-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             found
);
    assign found = |req;

    // scan from farthest to nearest so the request closest to ptr wins
    always_comb begin
        winner = '0;
        for (int i = CPU_N - 1; i >= 0; i--)
            if (req[ptr + IDX_W'(i)]) winner = ptr + IDX_W'(i);
    end
endmodule

// File: rtl/crossbar_scheduler.sv
// crossbar_scheduler: round-robin CPU-to-memory path scheduler with registered crossbar controls
module crossbar_scheduler
    import crossbar_pkg::*;
#(
    parameter int HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [1:0] req_mm_0,
    input  logic [1:0] req_mm_1,
    input  logic [1:0] req_mm_2,
    input  logic [1:0] req_mm_3,
    output logic [1:0] scheduler,
    output logic [1:0] select_0,
    output logic [1:0] select_1,
    output logic [1:0] select_2,
    output logic [1:0] select_3,
    output logic [3:0] grant,
    output logic       valid
);
    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d, win_q, win_d, mm_q, mm_d, sched_q, sched_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] sel_q [MM_N];
    logic [IDX_W-1:0] sel_d [MM_N];
    logic [CPU_N-1:0] grant_q, grant_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] arb_win;
    logic             arb_found;
    logic [IDX_W-1:0] mm_in [CPU_N];

    assign mm_in[0] = req_mm_0;
    assign mm_in[1] = req_mm_1;
    assign mm_in[2] = req_mm_2;
    assign mm_in[3] = req_mm_3;

    rr_arbiter u_arb (
        .req    (req),
        .ptr    (ptr_q),
        .winner (arb_win),
        .found  (arb_found)
    );

    // FSM: arbitrate, latch winner and target, hold the path, then advance the pointer
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        mm_d    = mm_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: state_d = (req != '0) ? ARB : IDLE;
            ARB: begin
                if (arb_found) begin
                    win_d   = arb_win;
                    mm_d    = mm_in[arb_win];
                    cnt_d   = '0;
                    state_d = GRANT;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(HOLD - 1) || !req[win_q]) state_d = RELEASE;
            end
            RELEASE: begin
                ptr_d   = win_q + 1'b1;
                state_d = (req != '0) ? ARB : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // crossbar controls follow the state one cycle later; scheduler/select hold outside GRANT
    always_comb begin
        valid_d = (state_q == GRANT);
        grant_d = valid_d ? onehot(win_q) : '0;
        sched_d = valid_d ? mm_q : sched_q;
        for (int m = 0; m < MM_N; m++)
            sel_d[m] = valid_d ? ((mm_q == IDX_W'(m)) ? win_q : '0) : sel_q[m];
    end

    // state and output registers, cleared immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            mm_q    <= '0;
            cnt_q   <= '0;
            sched_q <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            for (int m = 0; m < MM_N; m++) sel_q[m] <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            mm_q    <= mm_d;
            cnt_q   <= cnt_d;
            sched_q <= sched_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            for (int m = 0; m < MM_N; m++) sel_q[m] <= sel_d[m];
        end
    end

    assign scheduler = sched_q;
    assign select_0  = sel_q[0];
    assign select_1  = sel_q[1];
    assign select_2  = sel_q[2];
    assign select_3  = sel_q[3];
    assign grant     = grant_q;
    assign valid     = valid_q;
endmodule

// File: tb/tb_crossbar_scheduler.sv
// tb_crossbar_scheduler: directed checks of grant timing, rotation, latching and reset
module tb_crossbar_scheduler;
    logic       clk = 1'b0;
    logic       rst_n, rst1_n;
    logic [3:0] req, req1;
    logic [1:0] mm0, mm1, mm2, mm3;
    logic [1:0] sched, sel0, sel1, sel2, sel3;
    logic [1:0] sched1, s1_0, s1_1, s1_2, s1_3;
    logic [3:0] grant, grant1;
    logic       valid, valid1;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [3:0] ep_grant [8];
    logic [1:0] ep_sel0 [8];
    int         ep_len [8];
    int         got;

    always #5 clk = ~clk;

    crossbar_scheduler #(.HOLD(4)) u0 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .req_mm_0(mm0), .req_mm_1(mm1), .req_mm_2(mm2), .req_mm_3(mm3),
        .scheduler(sched), .select_0(sel0), .select_1(sel1), .select_2(sel2), .select_3(sel3),
        .grant(grant), .valid(valid)
    );

    crossbar_scheduler #(.HOLD(1)) u1 (
        .clk(clk), .rst_n(rst1_n), .req(req1),
        .req_mm_0(mm0), .req_mm_1(mm1), .req_mm_2(mm2), .req_mm_3(mm3),
        .scheduler(sched1), .select_0(s1_0), .select_1(s1_1), .select_2(s1_2), .select_3(s1_3),
        .grant(grant1), .valid(valid1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic collect(input bit use1, input int n, output int cnt);
        logic [3:0] g, prev;
        int len;
        cnt = 0;
        prev = '0;
        len = 0;
        for (int c = 0; c < 200 && cnt < n; c++) begin
            tick();
            g = use1 ? grant1 : grant;
            if (g != '0) begin
                if (prev == '0) begin
                    ep_grant[cnt] = g;
                    ep_sel0[cnt]  = use1 ? s1_0 : sel0;
                end
                len++;
            end else if (prev != '0) begin
                ep_len[cnt] = len;
                cnt++;
                len = 0;
            end
            prev = g;
        end
    endtask

    initial begin
        rst_n = 1'b0; rst1_n = 1'b0;
        req = '0; req1 = '0;
        mm0 = '0; mm1 = '0; mm2 = '0; mm3 = '0;
        #3;
        chk("reset_outputs", {sched, sel0, sel1, sel2, sel3, grant, valid}, '0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // single request, full HOLD length
        req = 4'b0001; mm0 = 2'd2;
        tick();
        chk("single_lat_k", valid, 0);
        tick();
        chk("single_lat_k1", valid, 0);
        tick();
        chk("single_valid", valid, 1);
        chk("single_grant", grant, 4'b0001);
        chk("single_sched", sched, 2);
        chk("single_selects", {sel0, sel1, sel2, sel3}, '0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("single_hold", valid, 1);
        end
        req = '0;
        tick();
        chk("single_release_valid", {grant, valid}, '0);
        chk("single_release_sched", sched, 2);

        // early drop in the second GRANT cycle
        tick();
        req = 4'b0010; mm1 = 2'd3;
        tick(); tick(); tick();
        chk("drop_grant", grant, 4'b0010);
        chk("drop_sched", sched, 3);
        chk("drop_sel3", sel3, 1);
        req = '0;
        tick();
        chk("drop_valid2", valid, 1);
        tick();
        chk("drop_release", valid, 0);
        tick();
        chk("drop_idle", valid, 0);

        // fairness rotation from reset
        rst_n = 1'b0;
        #1;
        req = 4'b1111; mm0 = '0; mm1 = '0; mm2 = '0; mm3 = '0;
        tick();
        rst_n = 1'b1;
        collect(0, 5, got);
        chk("rot_episodes", got, 5);
        chk("rot_g0", ep_grant[0], 4'b0001);
        chk("rot_g1", ep_grant[1], 4'b0010);
        chk("rot_g2", ep_grant[2], 4'b0100);
        chk("rot_g3", ep_grant[3], 4'b1000);
        chk("rot_g4", ep_grant[4], 4'b0001);
        chk("rot_sel0_2", ep_sel0[2], 2);
        chk("rot_sel0_3", ep_sel0[3], 3);
        chk("rot_len0", ep_len[0], 4);

        // latched target, then reset in the middle of the next grant
        rst_n = 1'b0;
        #1;
        req = 4'b0100; mm2 = 2'd1;
        #1;
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk("latch_grant", grant, 4'b0100);
        chk("latch_sched", sched, 1);
        chk("latch_sel1", sel1, 2);
        mm2 = 2'd3; req = 4'b0111;
        tick();
        chk("latch_sched_held", sched, 1);
        chk("latch_grant_held", grant, 4'b0100);
        req = 4'b1000;
        tick(); tick(); tick(); tick();
        chk("mid_grant_cpu3", grant, 4'b1000);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_outputs", {sched, sel0, sel1, sel2, sel3, grant, valid}, '0);
        req = 4'b1111;
        #1;
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk("after_reset_grant", grant, 4'b0001);

        // HOLD = 1 boundary
        req1 = 4'b1010;
        #1;
        rst1_n = 1'b1;
        collect(1, 3, got);
        chk("h1_episodes", got, 3);
        chk("h1_g0", ep_grant[0], 4'b0010);
        chk("h1_g1", ep_grant[1], 4'b1000);
        chk("h1_g2", ep_grant[2], 4'b0010);
        chk("h1_len0", ep_len[0], 1);
        chk("h1_len1", ep_len[1], 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/crossbar_scheduler.md
CROSSBAR_SCHEDULER -- requirements
Module: crossbar_scheduler

Interface
REQ-001 Parameter HOLD, default 4, maximum grant length in cycles per transfer; legal range 1..15.
REQ-002 clk  input  1  Single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  Reset, asynchronous and active-low.
REQ-004 req  input  4  Per-CPU request; bit k = cpu_k wants a memory module.
REQ-005 req_mm_0 .. req_mm_3  input  2 each  Target memory module index for cpu_0..cpu_3.
REQ-006 scheduler  output  2  Memory module currently connected; drives the crossbar scheduler input.
REQ-007 select_0 .. select_3  output  2 each  Destination CPU index for MM_0..MM_3; drives the crossbar select inputs.
REQ-008 grant  output  4  One-hot; bit k = cpu_k owns the path this cycle.
REQ-009 valid  output  1  High while a grant is active; data on the crossbar output is meaningful only when valid = 1.

Function
REQ-010 All outputs SHALL be registered.
REQ-011 The FSM SHALL have four states: IDLE, ARB, GRANT and RELEASE.
REQ-012 IDLE: valid = 0 and grant = 0; if req != 0 at a rising edge, next state is ARB, otherwise remain in IDLE.
REQ-013 ARB (one cycle): winner = first set req bit searching circularly from rr_ptr (0..3).
REQ-014 ARB: winner index and req_mm_<winner> SHALL be latched, the hold counter cleared, and next state is GRANT.
REQ-015 ARB: if req = 0 at the ARB edge, next state is IDLE with no grant.
REQ-016 GRANT: valid = 1, grant = one-hot(winner), scheduler = latched MM, select_<latched MM> = winner.
REQ-017 GRANT: all other select_n outputs SHALL be 0.
REQ-018 Latency: with req sampled at edge k in IDLE, valid and grant SHALL be high after edge k+2.
REQ-019 GRANT: the hold counter (4 bits) increments each cycle.
REQ-020 GRANT: leave for RELEASE when the counter reaches HOLD-1 or req[winner] = 0, whichever comes first, so valid lasts 1..HOLD cycles.
REQ-021 Changes to req_mm_<winner> or to other req bits during GRANT SHALL be ignored.
REQ-022 RELEASE (one cycle): valid = 0, grant = 0, scheduler and select hold their last values, rr_ptr = (winner+1) mod 4.
REQ-023 RELEASE: next state is ARB if req != 0, else IDLE.
REQ-024 Two CPUs targeting the same MM SHALL be served sequentially; at most one grant bit is set at any time.
REQ-025 With all four req held high from reset, grants SHALL rotate cpu_0, 1, 2, 3, 0, ... with no starvation.

Reset
REQ-026 rst_n low SHALL immediately force state = IDLE and rr_ptr = 0.
REQ-027 rst_n low SHALL immediately clear the counter, scheduler, select_0..3, grant and valid to 0, including mid-GRANT.
REQ-028 After rst_n deasserts, the first arbitration SHALL begin from rr_ptr = 0.

Structure
REQ-029 Shared package crossbar_pkg SHALL hold: CPU count (4), MM count (4), index width (2), data width (8), and the FSM state enumeration.
REQ-030 One combinational sub-module rr_arbiter (inputs req[3:0] and ptr[1:0]; outputs winner[1:0] and found) SHALL perform the circular priority search.

Verification
REQ-031 Single request: req = 0001, req_mm_0 = 2, HOLD = 4 -> valid high for 4 cycles starting 2 edges after the request, with scheduler = 2, select_2 = 0, grant = 0001.
REQ-032 Early drop: req[1] high with req_mm_1 = 3, then dropped in the 2nd GRANT cycle -> valid lasts 2 cycles, then RELEASE, then IDLE.
REQ-033 Fairness: req = 1111 with all targets 0 -> grant sequence 0001, 0010, 0100, 1000, 0001, separated by one RELEASE cycle each.
REQ-034 Latched target: req_mm_2 changes 1 -> 3 during cpu_2's GRANT -> scheduler stays 1 for that grant.
REQ-035 Reset mid-grant: rst_n pulled low in the 2nd GRANT cycle -> all outputs 0 immediately; the next grant with req = 1111 goes to cpu_0.
REQ-036 Boundary: HOLD = 1 with req = 1010 -> single-cycle grants to cpu_1, then cpu_3, then cpu_1.
